// File: rtl/regfile_pkg.sv
// Shared defaults for the scoreboarded register file and the pending-write counter type.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_CNT_W  = 2;

  typedef logic [DEF_CNT_W-1:0] cnt_t;

endpackage

// File: rtl/regfile_rdport.sv
// One read port: register mux with optional same-cycle write forwarding and busy flag.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int BYPASS = 1
) (
  input  logic [ADDR_W-1:0]                i_raddr,
  input  logic [(2**ADDR_W)*DATA_W-1:0]    i_mem,
  input  logic [(2**ADDR_W)*CNT_W-1:0]     i_cnt,
  input  logic                             i_we,
  input  logic [ADDR_W-1:0]                i_waddr,
  input  logic [DATA_W-1:0]                i_wdata,
  output logic [DATA_W-1:0]                o_rdata,
  output logic                             o_rbusy
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DATA_W-1:0] w_mem;
  logic [CNT_W-1:0]  w_cnt;
  logic              w_zero;
  logic              w_hit;

  assign w_mem  = i_mem[int'(i_raddr)*DATA_W +: DATA_W];
  assign w_cnt  = i_cnt[int'(i_raddr)*CNT_W +: CNT_W];
  assign w_zero = (i_raddr == '0);
  assign w_hit  = (BYPASS != 0) && i_we && (i_waddr == i_raddr) && !w_zero;

  always_comb begin
    o_rdata = '0;
    if (!w_zero) o_rdata = w_hit ? i_wdata : w_mem;
    // The forwarded write only hides busy when it retires the last pending write.
    o_rbusy = (w_cnt != '0) && !(w_hit && (w_cnt == CNT_ONE));
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with per-register pending-write scoreboard, reservation handshake and flush.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int CNT_W  = $bits(cnt_t),
  parameter int BYPASS = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [NUM_RD*ADDR_W-1:0]   raddr,
  output logic [NUM_RD*DATA_W-1:0]   rdata,
  output logic [NUM_RD-1:0]          rbusy,
  input  logic                       rsv_valid,
  input  logic [ADDR_W-1:0]          rsv_addr,
  output logic                       rsv_ready,
  input  logic                       flush,
  output logic                       wb_err
);

  localparam int NREG = 2**ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DATA_W-1:0] r_mem     [NREG];
  logic [CNT_W-1:0]  r_cnt     [NREG];
  logic [CNT_W-1:0]  w_cnt_nxt [NREG];
  logic              r_wb_err;

  logic [NREG*DATA_W-1:0] w_mem_flat;
  logic [NREG*CNT_W-1:0]  w_cnt_flat;

  logic w_wr;
  logic w_retire;
  logic w_unres;
  logic w_accept;
  logic w_same;

  assign w_wr      = we && (waddr != '0);
  assign w_retire  = w_wr && (r_cnt[waddr] != '0);
  assign w_unres   = w_wr && (r_cnt[waddr] == '0);
  assign rsv_ready = (r_cnt[rsv_addr] != CNT_MAX) || (w_retire && (waddr == rsv_addr));
  assign w_accept  = rsv_valid && rsv_ready && (rsv_addr != '0);
  assign w_same    = w_accept && w_retire && (waddr == rsv_addr);

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      w_cnt_nxt[r] = r_cnt[r];
      if (flush) begin
        w_cnt_nxt[r] = '0;
      end else if (!w_same) begin
        // Retire and accept on different registers are independent; same register cancels.
        if (w_accept && (rsv_addr == ADDR_W'(r)) && (r_cnt[r] != CNT_MAX))
          w_cnt_nxt[r] = r_cnt[r] + CNT_ONE;
        else if (w_retire && (waddr == ADDR_W'(r)))
          w_cnt_nxt[r] = r_cnt[r] - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) r_mem[r] <= '0;
    end else if (w_wr) begin
      r_mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) r_cnt[r] <= '0;
      r_wb_err <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) r_cnt[r] <= w_cnt_nxt[r];
      r_wb_err <= w_unres;
    end
  end

  assign wb_err = r_wb_err;

  genvar g;
  generate
    for (g = 0; g < NREG; g++) begin : g_flat
      assign w_mem_flat[g*DATA_W +: DATA_W] = r_mem[g];
      assign w_cnt_flat[g*CNT_W +: CNT_W]   = r_cnt[g];
    end

    for (g = 0; g < NUM_RD; g++) begin : g_rd
      regfile_rdport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W),
        .BYPASS (BYPASS)
      ) u_rdport (
        .i_raddr (raddr[g*ADDR_W +: ADDR_W]),
        .i_mem   (w_mem_flat),
        .i_cnt   (w_cnt_flat),
        .i_we    (we),
        .i_waddr (waddr),
        .i_wdata (wdata),
        .o_rdata (rdata[g*DATA_W +: DATA_W]),
        .o_rbusy (rbusy[g])
      );
    end
  endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// Directed and random checks of regfile_sb, forwarding on and off, against a behavioural scoreboard model.
module tb_regfile_sb;

  localparam int DW   = 32;
  localparam int AW   = 4;
  localparam int NR   = 3;
  localparam int CW   = 2;
  localparam int NREG = 16;
  localparam int CMAX = 3;

  logic            clk;
  logic            rst_n;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [DW-1:0]   wdata;
  logic [NR*AW-1:0] raddr;
  logic            rsv_valid;
  logic [AW-1:0]   rsv_addr;
  logic            flush;

  logic [NR*DW-1:0] rdata_b, rdata_n;
  logic [NR-1:0]    rbusy_b, rbusy_n;
  logic             rsv_ready_b, rsv_ready_n;
  logic             wb_err_b, wb_err_n;

  int n_chk;
  int n_err;

  logic [DW-1:0] m_mem [NREG];
  int            m_cnt [NREG];
  logic          m_wb_err;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .CNT_W(CW), .BYPASS(1)) u_byp (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready_b),
    .flush(flush), .wb_err(wb_err_b)
  );

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .CNT_W(CW), .BYPASS(0)) u_nobyp (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready_n),
    .flush(flush), .wb_err(wb_err_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model view of what each output must be, from the architectural rules.
  function automatic int ra(input int i);
    ra = int'(raddr[i*AW +: AW]);
  endfunction

  function automatic logic [DW-1:0] exp_rdata(input int i, input bit byp);
    int a;
    a = ra(i);
    if (a == 0) return '0;
    if (byp && we && int'(waddr) == a) return wdata;
    return m_mem[a];
  endfunction

  function automatic logic exp_rbusy(input int i, input bit byp);
    int a;
    a = ra(i);
    if (m_cnt[a] == 0) return 1'b0;
    if (byp && we && int'(waddr) == a && m_cnt[a] == 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic exp_ready();
    int a;
    a = int'(rsv_addr);
    if (m_cnt[a] < CMAX) return 1'b1;
    return we && int'(waddr) == a;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        m_mem[r] = '0;
        m_cnt[r] = 0;
      end
      m_wb_err = 1'b0;
    end else begin
      int wa, sa;
      bit acc, ret;
      wa  = int'(waddr);
      sa  = int'(rsv_addr);
      acc = rsv_valid && exp_ready() && sa != 0;
      ret = we && wa != 0 && m_cnt[wa] != 0;
      m_wb_err = we && wa != 0 && m_cnt[wa] == 0;
      if (we && wa != 0) m_mem[wa] = wdata;
      if (flush) begin
        for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
      end else if (!(acc && ret && sa == wa)) begin
        if (ret) m_cnt[wa] = m_cnt[wa] - 1;
        if (acc && m_cnt[sa] < CMAX) m_cnt[sa] = m_cnt[sa] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NR; i++) begin
        chk("cmp_rdata_byp",   rdata_b[i*DW +: DW], exp_rdata(i, 1'b1));
        chk("cmp_rdata_nobyp", rdata_n[i*DW +: DW], exp_rdata(i, 1'b0));
        chk("cmp_rbusy_byp",   DW'(rbusy_b[i]), DW'(exp_rbusy(i, 1'b1)));
        chk("cmp_rbusy_nobyp", DW'(rbusy_n[i]), DW'(exp_rbusy(i, 1'b0)));
      end
      chk("cmp_ready_byp",   DW'(rsv_ready_b), DW'(exp_ready()));
      chk("cmp_ready_nobyp", DW'(rsv_ready_n), DW'(exp_ready()));
      chk("cmp_wberr_byp",   DW'(wb_err_b), DW'(m_wb_err));
      chk("cmp_wberr_nobyp", DW'(wb_err_n), DW'(m_wb_err));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; rsv_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic set_ra(input int i, input int a);
    raddr[i*AW +: AW] = AW'(a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_err = 0;
    rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
    rsv_valid = 1'b0; rsv_addr = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdata0", rdata_b[31:0], 32'h0);
    chk("rst_rbusy",  DW'(rbusy_b), 32'h0);
    chk("rst_ready",  DW'(rsv_ready_b), 32'h1);
    chk("rst_wberr",  DW'(wb_err_b), 32'h0);
    rst_n = 1'b1;
    cyc();

    // Write with forwarding, then register 0 writes ignored.
    we = 1'b1; waddr = 4'd5; wdata = 32'hDEADBEEF; set_ra(0, 5);
    #1;
    chk("byp_same",   rdata_b[31:0], 32'hDEADBEEF);
    chk("nobyp_same", rdata_n[31:0], 32'h0);
    cyc(); idle();
    #1;
    chk("byp_next",   rdata_b[31:0], 32'hDEADBEEF);
    chk("nobyp_next", rdata_n[31:0], 32'hDEADBEEF);
    chk("model_r5",   m_mem[5], 32'hDEADBEEF);
    we = 1'b1; waddr = 4'd0; wdata = 32'h12345678; set_ra(0, 0);
    #1;
    chk("r0_same", rdata_b[31:0], 32'h0);
    cyc(); idle();
    #1;
    chk("r0_next_byp",   rdata_b[31:0], 32'h0);
    chk("r0_next_nobyp", rdata_n[31:0], 32'h0);

    // Saturate r7.
    rsv_valid = 1'b1; rsv_addr = 4'd7; set_ra(0, 7);
    repeat (3) cyc();
    #1;
    chk("sat_ready",  DW'(rsv_ready_b), 32'h0);
    chk("sat_busy",   DW'(rbusy_b[0]), 32'h1);
    chk("model_cnt7", DW'(m_cnt[7]), 32'd3);
    we = 1'b1; waddr = 4'd7; wdata = 32'h77;
    #1;
    chk("sat_ready_wb", DW'(rsv_ready_b), 32'h1);
    cyc();
    we = 1'b0;
    #1;
    chk("sat_hold",  DW'(rsv_ready_b), 32'h0);
    chk("sat_data",  rdata_b[31:0], 32'h77);
    chk("sat_wberr", DW'(wb_err_b), 32'h0);
    idle();

    // Retirement of two reservations on r9, then one unreserved writeback.
    rsv_valid = 1'b1; rsv_addr = 4'd9;
    cyc(); cyc(); idle(); set_ra(1, 9);
    #1;
    chk("ret_busy0", DW'(rbusy_b[1]), 32'h1);
    we = 1'b1; waddr = 4'd9; wdata = 32'h91;
    #1;
    chk("ret_wb1_byp", DW'(rbusy_b[1]), 32'h1);
    cyc(); idle();
    #1;
    chk("ret_busy1", DW'(rbusy_b[1]), 32'h1);
    we = 1'b1; waddr = 4'd9; wdata = 32'h92;
    #1;
    chk("ret_wb2_byp",   DW'(rbusy_b[1]), 32'h0);
    chk("ret_wb2_nobyp", DW'(rbusy_n[1]), 32'h1);
    cyc(); idle();
    #1;
    chk("ret_busy2",   DW'(rbusy_b[1]), 32'h0);
    chk("ret_nowberr", DW'(wb_err_b), 32'h0);
    we = 1'b1; waddr = 4'd9; wdata = 32'h93;
    cyc(); idle();
    #1;
    chk("wberr_pulse_byp",   DW'(wb_err_b), 32'h1);
    chk("wberr_pulse_nobyp", DW'(wb_err_n), 32'h1);
    chk("wberr_data",        rdata_b[63:32], 32'h93);
    cyc();
    chk("wberr_clear", DW'(wb_err_b), 32'h0);

    // Flush overrides a same-cycle reservation.
    rsv_valid = 1'b1; rsv_addr = 4'd3;
    cyc();
    rsv_addr = 4'd4;
    cyc(); idle(); set_ra(0, 3); set_ra(1, 4);
    #1;
    chk("fl_busy3_pre", DW'(rbusy_b[0]), 32'h1);
    chk("fl_busy4_pre", DW'(rbusy_b[1]), 32'h1);
    flush = 1'b1; rsv_valid = 1'b1; rsv_addr = 4'd3;
    cyc(); idle();
    #1;
    chk("fl_busy3", DW'(rbusy_b[0]), 32'h0);
    chk("fl_busy4", DW'(rbusy_b[1]), 32'h0);
    chk("fl_busy4_nobyp", DW'(rbusy_n[1]), 32'h0);

    // Random traffic, checked every cycle by the compare process.
    for (int k = 0; k < 400; k++) begin
      we        = ($urandom_range(0, 1) == 1);
      waddr     = AW'($urandom_range(0, 7));
      wdata     = $urandom();
      for (int i = 0; i < NR; i++) set_ra(i, $urandom_range(0, 7));
      rsv_valid = ($urandom_range(0, 1) == 1);
      rsv_addr  = AW'($urandom_range(0, 7));
      flush     = ($urandom_range(0, 31) == 0);
      cyc();
    end

    // Reset asserted between edges with traffic still applied.
    we = 1'b1; waddr = 4'd2; wdata = 32'hA5A5A5A5; rsv_valid = 1'b1; rsv_addr = 4'd7;
    set_ra(0, 5); set_ra(1, 6); set_ra(2, 7); flush = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NR; i++) begin
      chk("arst_rdata_byp",   rdata_b[i*DW +: DW], 32'h0);
      chk("arst_rdata_nobyp", rdata_n[i*DW +: DW], 32'h0);
    end
    chk("arst_rbusy", DW'(rbusy_b), 32'h0);
    chk("arst_ready", DW'(rsv_ready_b), 32'h1);
    chk("arst_wberr", DW'(wb_err_b), 32'h0);
    rst_n = 1'b1;

    for (int k = 0; k < 60; k++) begin
      we        = ($urandom_range(0, 1) == 1);
      waddr     = AW'($urandom_range(0, 15));
      wdata     = $urandom();
      for (int i = 0; i < NR; i++) set_ra(i, $urandom_range(0, 15));
      rsv_valid = ($urandom_range(0, 3) != 0);
      rsv_addr  = AW'($urandom_range(0, 15));
      flush     = ($urandom_range(0, 31) == 0);
      cyc();
    end
    idle();
    cyc();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; the register count is 2**ADDR_W.
REQ-003 SHALL have parameter NUM_RD, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter CNT_W, default 2, width of the per-register pending-write counter.
REQ-005 SHALL have parameter BYPASS, default 1, which enables write-to-read forwarding in the same cycle.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-008 SHALL have port we, input, 1 bit, writeback strobe.
REQ-009 SHALL have port waddr, input, ADDR_W bits, writeback register.
REQ-010 SHALL have port wdata, input, DATA_W bits, writeback data.
REQ-011 SHALL have port raddr, input, NUM_RD x ADDR_W bits, read addresses.
REQ-012 SHALL have port rdata, output, NUM_RD x DATA_W bits, read data, combinational.
REQ-013 SHALL have port rbusy, output, NUM_RD bits, which flags that the addressed register has a pending write.
REQ-014 SHALL have port rsv_valid, input, 1 bit, issue-stage destination reservation request.
REQ-015 SHALL have port rsv_addr, input, ADDR_W bits, register to reserve.
REQ-016 SHALL have port rsv_ready, output, 1 bit, which indicates that the reservation can be accepted this cycle.
REQ-017 SHALL have port flush, input, 1 bit, which clears all reservations.
REQ-018 SHALL have port wb_err, output, 1 bit, a registered one-cycle pulse flagging an unreserved writeback.

Function
REQ-019 SHALL hard-wire register 0: reads return 0, writes are ignored, it is never reserved, and rbusy is 0 for it.
REQ-020 SHALL update mem[waddr] <= wdata on a rising edge when we=1 and waddr!=0.
REQ-021 SHALL, when BYPASS=1, we=1, waddr==raddr[i] and waddr!=0, drive rdata[i]=wdata in the same cycle; otherwise rdata[i]=mem[raddr[i]].
REQ-022 SHALL keep a pending counter cnt[r] of CNT_W bits per register.
REQ-023 SHALL define a reservation as accepted when rsv_valid=1, rsv_ready=1 and rsv_addr!=0; an accepted reservation increments cnt[rsv_addr].
REQ-024 SHALL drive rsv_ready=0 only when cnt[rsv_addr]==2**CNT_W-1 and there is no same-cycle retiring writeback to rsv_addr; rsv_ready is combinational.
REQ-025 SHALL treat a retiring writeback (we=1, waddr!=0, cnt[waddr]!=0) as decrementing cnt[waddr].
REQ-026 SHALL leave cnt unchanged when an accepted reservation and a retiring writeback hit the same register in the same cycle.
REQ-027 SHALL, on a writeback with cnt[waddr]==0 and waddr!=0, still write the data, leave cnt at 0 and pulse wb_err the next cycle.
REQ-028 SHALL compute rbusy[i]=(cnt[raddr[i]]!=0) from the registered counter; a same-cycle retiring writeback clears rbusy[i] only when BYPASS=1 and cnt==1.
REQ-029 SHALL, on flush=1, set all cnt to 0 at the edge, overriding same-cycle reservations and decrements; the data write still occurs.
REQ-030 SHALL never wrap a counter: no increment at the maximum and no decrement at 0.

Reset
REQ-031 SHALL, on rst_n=0, asynchronously clear all mem entries, all cnt and wb_err to 0; rdata then reads 0, rbusy=0 and rsv_ready=1.
REQ-032 SHALL make reset dominate any in-flight reservation or writeback; the first update occurs on the first rising edge after rst_n deasserts.

Structure
REQ-033 SHALL place the default constants (DATA_W, ADDR_W, CNT_W) and a typedef for the pending counter in a shared package, regfile_pkg.
REQ-034 SHALL implement the read path as one sub-module, regfile_rdport, instantiated NUM_RD times; it handles mux, bypass and rbusy.

Verification
REQ-035 SHALL verify reset: assert rst_n=0 mid-traffic -> every rdata=0, rbusy=0, rsv_ready=1 immediately, without a clock edge.
REQ-036 SHALL verify write and bypass: we=1, waddr=5, wdata=0xDEADBEEF with raddr[0]=5 -> rdata[0]=0xDEADBEEF in the same cycle with BYPASS=1, and the next cycle with BYPASS=0; waddr=0 -> r0 still reads 0.
REQ-037 SHALL verify saturation: reserve r7 three times (CNT_W=2) -> rsv_ready=0 for r7; a simultaneous reserve plus writeback to r7 is accepted and cnt stays at 3.
REQ-038 SHALL verify retirement: reserve r9 twice, then two writebacks -> rbusy for r9 is 1,1,0 across the writebacks; a third writeback -> data is written and wb_err pulses for one cycle.
REQ-039 SHALL verify flush: reservations pending on r3 and r4, then flush together with rsv_valid on r3 -> next cycle cnt[r3]=0 and cnt[r4]=0, and rbusy is 0.
REQ-040 SHALL verify random ops against a reference model with NUM_RD=3 and ADDR_W=4 -> rdata, rbusy and rsv_ready match the model every cycle.
